// File: rtl/controller_fsm_mc_if.sv
// Control bundle between the multi-cycle controller and the datapath / instruction memory.
// The controller takes the master side; the datapath or a testbench takes the slave side.
interface controller_fsm_mc_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 4
);
  logic [OP_W-1:0]  Opcode;
  logic [CNT_W-1:0] ShAmt;
  logic             Z;
  logic             C;
  logic             IMemAck;
  logic             Resume;
  logic             IMemReq;
  logic             LoadIR;
  logic             IncPC;
  logic             SelPC;
  logic             LoadPC;
  logic             LoadReg;
  logic             LoadAcc;
  logic [1:0]       SelAcc;
  logic [OP_W-1:0]  SelALU;
  logic             Halted;
  logic [1:0]       Fault;
  logic [2:0]       State;

  modport master (
    input  Opcode, ShAmt, Z, C, IMemAck, Resume,
    output IMemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
           SelAcc, SelALU, Halted, Fault, State
  );

  modport slave (
    output Opcode, ShAmt, Z, C, IMemAck, Resume,
    input  IMemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
           SelAcc, SelALU, Halted, Fault, State
  );
endinterface

// File: rtl/controller_fsm_mc.sv
// Multi-cycle accumulator-CPU controller: FETCH/DECODE/EXEC sequencing with multi-cycle
// shifts, conditional jumps, resumable HALT and sticky fault trapping.
module controller_fsm_mc #(
  parameter int OP_W    = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  controller_fsm_mc_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP    = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_NOR    = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_R2A    = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_A2R    = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_JZR    = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_JZI    = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_JNZR   = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_JCI    = OP_W'(4'h9);
  localparam logic [OP_W-1:0] OP_JNZI   = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_SHFL   = OP_W'(4'hB);
  localparam logic [OP_W-1:0] OP_SHFR   = OP_W'(4'hC);
  localparam logic [OP_W-1:0] OP_I2A    = OP_W'(4'hD);
  localparam logic [OP_W-1:0] OP_ILL    = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(4'hF);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] sh_q, sh_d;
  logic [1:0]       fault_q, fault_d;

  logic [CNT_W:0]   cnt_inc;
  logic             illegal;

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign illegal = ((bus.Opcode >> 4) != '0) || (bus.Opcode == OP_ILL);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sh_q    <= '0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sh_d        = sh_q;
    fault_d     = fault_q;
    bus.IMemReq = 1'b0;
    bus.LoadIR  = 1'b0;
    bus.IncPC   = 1'b0;
    bus.SelPC   = 1'b0;
    bus.LoadPC  = 1'b0;
    bus.LoadReg = 1'b0;
    bus.LoadAcc = 1'b0;
    bus.SelAcc  = 2'b00;
    bus.SelALU  = OP_NOP;
    bus.Halted  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        bus.IMemReq = 1'b1;
        if (bus.IMemAck) begin
          bus.LoadIR = 1'b1;
          cnt_d      = '0;
          state_d    = S_DECODE;
        end else if (TIMEOUT != 0 && cnt_inc == (CNT_W+1)'(TIMEOUT)) begin
          cnt_d   = '0;
          fault_d = 2'b10;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      S_DECODE: begin
        op_d = bus.Opcode;
        sh_d = bus.ShAmt;
        if (illegal) begin
          fault_d = 2'b01;
          state_d = S_FAULT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_ADD, OP_SUB, OP_NOR: begin
            bus.LoadAcc = 1'b1;
            bus.SelAcc  = 2'b11;
            bus.SelALU  = op_q;
            bus.IncPC   = 1'b1;
          end
          OP_SHFL, OP_SHFR: begin
            // sh_q doubles as the remaining-cycle counter; zero means no shift at all
            if (sh_q == '0) begin
              bus.IncPC = 1'b1;
            end else begin
              bus.LoadAcc = 1'b1;
              bus.SelAcc  = 2'b11;
              bus.SelALU  = op_q;
              sh_d        = sh_q - CNT_W'(1);
              if (sh_q == CNT_W'(1)) begin
                bus.IncPC = 1'b1;
              end else begin
                state_d = S_EXEC;
              end
            end
          end
          OP_R2A: begin
            bus.LoadAcc = 1'b1;
            bus.SelAcc  = 2'b01;
            bus.IncPC   = 1'b1;
          end
          OP_A2R: begin
            bus.LoadReg = 1'b1;
            bus.IncPC   = 1'b1;
          end
          OP_I2A: begin
            bus.LoadAcc = 1'b1;
            bus.SelAcc  = 2'b00;
            bus.IncPC   = 1'b1;
          end
          OP_JZR, OP_JZI, OP_JNZR, OP_JNZI, OP_JCI: begin
            if ((op_q == OP_JZR  &&  bus.Z) || (op_q == OP_JZI  &&  bus.Z) ||
                (op_q == OP_JNZR && !bus.Z) || (op_q == OP_JNZI && !bus.Z) ||
                (op_q == OP_JCI  &&  bus.C)) begin
              bus.LoadPC = 1'b1;
              bus.SelPC  = (op_q != OP_JZR) && (op_q != OP_JNZR);
              bus.SelALU = op_q;
            end else begin
              bus.IncPC = 1'b1;
            end
          end
          OP_HALT: begin
            bus.IncPC  = 1'b1;
            bus.SelALU = op_q;
            state_d    = S_HALTED;
          end
          default: bus.IncPC = 1'b1;
        endcase
      end

      S_HALTED: begin
        bus.Halted = 1'b1;
        if (bus.Resume) state_d = S_FETCH;
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Fault = fault_q;
  assign bus.State = state_q;

endmodule

// File: tb/tb_controller_fsm_mc.sv
// Directed bench for controller_fsm_mc: the driver queues the expected output word for
// each cycle it drives, and an independent monitor pops and compares them.
module tb_controller_fsm_mc;

  logic Clk = 1'b0;
  logic reset_n;

  controller_fsm_mc_if #(.OP_W(4), .CNT_W(4)) bus ();

  controller_fsm_mc #(.OP_W(4), .CNT_W(4), .TIMEOUT(15)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [18:0] vec;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event mon_ev;

  function automatic logic [18:0] ev(input logic [2:0] st, input logic req, input logic ir,
                                     input logic inc, input logic spc, input logic lpc,
                                     input logic lreg, input logic lacc, input logic [1:0] sacc,
                                     input logic [3:0] alu, input logic hlt, input logic [1:0] flt);
    return {req, ir, inc, spc, lpc, lreg, lacc, sacc, alu, hlt, flt, st};
  endfunction

  function automatic logic [18:0] ex(input logic inc, input logic spc, input logic lpc,
                                     input logic lreg, input logic lacc, input logic [1:0] sacc,
                                     input logic [3:0] alu);
    return ev(3'd3, 1'b0, 1'b0, inc, spc, lpc, lreg, lacc, sacc, alu, 1'b0, 2'b00);
  endfunction

  logic [18:0] E_IDLE, E_FETCH, E_FETCH_NA, E_DEC, E_HALT, E_FLT_TO, E_FLT_ILL;
  initial begin
    E_IDLE     = ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 2'b00);
    E_FETCH    = ev(3'd1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 2'b00);
    E_FETCH_NA = ev(3'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 2'b00);
    E_DEC      = ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 2'b00);
    E_HALT     = ev(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 1, 2'b00);
    E_FLT_TO   = ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 2'b10);
    E_FLT_ILL  = ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 2'b01);
  end

  // Monitor: compares on every falling edge, or immediately when an async check is requested.
  always begin
    @(negedge Clk or mon_ev);
    if (sb.size() != 0) begin
      exp_t e;
      logic [18:0] act;
      e   = sb.pop_front();
      act = {bus.IMemReq, bus.LoadIR, bus.IncPC, bus.SelPC, bus.LoadPC, bus.LoadReg,
             bus.LoadAcc, bus.SelAcc, bus.SelALU, bus.Halted, bus.Fault, bus.State};
      n_cmp++;
      if (act !== e.vec) begin
        n_bad++;
        $display("FAIL %s: got %b required %b (req ir inc spc lpc lreg lacc sacc alu hlt flt st)",
                 e.name, act, e.vec);
      end else begin
        $display("ok   %s: %b", e.name, act);
      end
    end
  end

  task automatic cyc(input logic ack, input logic [3:0] op, input logic [3:0] sh,
                     input logic z, input logic c, input logic rs,
                     input logic [18:0] e, input string nm);
    @(posedge Clk);
    #1;
    bus.IMemAck = ack;
    bus.Opcode  = op;
    bus.ShAmt   = sh;
    bus.Z       = z;
    bus.C       = c;
    bus.Resume  = rs;
    sb.push_back('{e, nm});
  endtask

  task automatic instr(input logic [3:0] op, input logic [3:0] sh, input logic z,
                       input logic c, input logic [18:0] e_exec, input string nm);
    cyc(1'b1, op, sh, z, c, 1'b0, E_FETCH, {nm, "_fetch"});
    cyc(1'b1, op, sh, z, c, 1'b0, E_DEC,   {nm, "_decode"});
    cyc(1'b1, op, sh, z, c, 1'b0, e_exec,  {nm, "_exec"});
  endtask

  task automatic async_reset(input string nm);
    @(negedge Clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back('{E_IDLE, nm});
    -> mon_ev;
  endtask

  task automatic release_reset(input logic [3:0] op);
    @(posedge Clk);
    #1;
    reset_n     = 1'b1;
    bus.IMemAck = 1'b1;
    bus.Opcode  = op;
    bus.ShAmt   = 4'd0;
    bus.Resume  = 1'b0;
    sb.push_back('{E_IDLE, "idle_after_reset"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    bus.IMemAck = 1'b0;
    bus.Opcode  = 4'h0;
    bus.ShAmt   = 4'h0;
    bus.Z       = 1'b0;
    bus.C       = 1'b0;
    bus.Resume  = 1'b0;
    #3;
    sb.push_back('{E_IDLE, "reset_state"});
    -> mon_ev;
    repeat (2) @(posedge Clk);
    release_reset(4'h1);

    instr(4'h1, 4'd0, 0, 0, ex(1, 0, 0, 0, 1, 2'b11, 4'h1), "add");
    instr(4'hD, 4'd0, 0, 0, ex(1, 0, 0, 0, 1, 2'b00, 4'h0), "imm_to_acc");
    instr(4'h2, 4'd0, 0, 0, ex(1, 0, 0, 0, 1, 2'b11, 4'h2), "sub");

    // SHFL by 3: three EXEC cycles, PC advances only on the last
    cyc(1, 4'hB, 4'd3, 0, 0, 0, E_FETCH, "shfl3_fetch");
    cyc(1, 4'hB, 4'd3, 0, 0, 0, E_DEC,   "shfl3_decode");
    cyc(1, 4'hB, 4'd3, 0, 0, 0, ex(0, 0, 0, 0, 1, 2'b11, 4'hB), "shfl3_exec1");
    cyc(1, 4'hB, 4'd3, 0, 0, 0, ex(0, 0, 0, 0, 1, 2'b11, 4'hB), "shfl3_exec2");
    cyc(1, 4'hB, 4'd3, 0, 0, 0, ex(1, 0, 0, 0, 1, 2'b11, 4'hB), "shfl3_exec3");
    instr(4'hB, 4'd0, 0, 0, ex(1, 0, 0, 0, 0, 2'b00, 4'h0), "shfl0");

    instr(4'h4, 4'd0, 0, 0, ex(1, 0, 0, 0, 1, 2'b01, 4'h0), "reg_to_acc");
    instr(4'h5, 4'd0, 0, 0, ex(1, 0, 0, 1, 0, 2'b00, 4'h0), "acc_to_reg");
    instr(4'h7, 4'd0, 1, 0, ex(0, 1, 1, 0, 0, 2'b00, 4'h7), "jmpz_imm_taken");
    instr(4'h7, 4'd0, 0, 0, ex(1, 0, 0, 0, 0, 2'b00, 4'h0), "jmpz_imm_not");
    instr(4'h8, 4'd0, 0, 0, ex(0, 0, 1, 0, 0, 2'b00, 4'h8), "jmpnz_reg_taken");
    instr(4'h8, 4'd0, 1, 0, ex(1, 0, 0, 0, 0, 2'b00, 4'h0), "jmpnz_reg_not");
    instr(4'h9, 4'd0, 0, 1, ex(0, 1, 1, 0, 0, 2'b00, 4'h9), "jmpc_imm_taken");
    instr(4'h9, 4'd0, 1, 0, ex(1, 0, 0, 0, 0, 2'b00, 4'h0), "jmpc_imm_not");
    instr(4'h0, 4'd0, 0, 0, ex(1, 0, 0, 0, 0, 2'b00, 4'h0), "nop");

    // HALT, then ten halted cycles with a stray ack that must be ignored
    instr(4'hF, 4'd0, 0, 0, ex(1, 0, 0, 0, 0, 2'b00, 4'hF), "halt");
    for (int i = 0; i < 10; i++) cyc(1, 4'h0, 4'd0, 0, 0, 0, E_HALT, "halted");
    cyc(0, 4'h0, 4'd0, 0, 0, 1, E_HALT, "halted_resume");

    // Resumed fetch never acked: 15 FETCH cycles then the timeout fault
    for (int i = 0; i < 15; i++) cyc(0, 4'h0, 4'd0, 0, 0, 0, E_FETCH_NA, "fetch_wait");
    for (int i = 0; i < 3; i++) cyc(i[0], 4'h0, 4'd0, 0, 0, 1, E_FLT_TO, "fault_timeout");

    async_reset("async_reset_from_fault");
    release_reset(4'hE);
    cyc(1, 4'hE, 4'd0, 0, 0, 0, E_FETCH, "ill_fetch");
    cyc(1, 4'hE, 4'd0, 0, 0, 0, E_DEC,   "ill_decode");
    for (int i = 0; i < 3; i++) cyc(1, 4'h1, 4'd0, 0, 0, 1, E_FLT_ILL, "fault_illegal");

    async_reset("async_reset_from_ill");
    release_reset(4'hC);
    cyc(1, 4'hC, 4'd3, 0, 0, 0, E_FETCH, "shfr3_fetch");
    cyc(1, 4'hC, 4'd3, 0, 0, 0, E_DEC,   "shfr3_decode");
    cyc(1, 4'hC, 4'd3, 0, 0, 0, ex(0, 0, 0, 0, 1, 2'b11, 4'hC), "shfr3_exec1");
    cyc(1, 4'hC, 4'd3, 0, 0, 0, ex(0, 0, 0, 0, 1, 2'b11, 4'hC), "shfr3_exec2");
    async_reset("async_reset_mid_shift");
    release_reset(4'h0);
    cyc(1, 4'h0, 4'd0, 0, 0, 0, E_FETCH, "fetch_after_reset");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending entries required 0", sb.size());
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
